// File: rtl/usb_host_token_tx.sv
// usb_host_token_tx
// Host-side USB full-speed token transmitter. On an accepted start it sends one
// token packet on the tx pair: SYNC, PID, ADDR, ENDP and CRC5, with bit stuffing
// and NRZI coding, followed by an EOP. It then watches the rx pair for the start
// of the device response during a bounded turnaround window.
//
// Optional feature macro: TOKEN_PID_SEL_EN. When defined, a pid_sel input picks
// the token PID (00 IN, 01 OUT, 10 SETUP, 11 IN). When undefined, the PID is IN.
//
// Ports:
//   clk, n_rst              clock, asynchronous active-low reset
//   start                   request a token (sampled only while idle)
//   addr[6:0], endp[3:0]    token fields, captured when start is accepted
//   pid_sel[1:0]            PID select (only with TOKEN_PID_SEL_EN)
//   rx_d_plus, rx_d_minus   bus pair as seen by the host
//   tx_d_plus, tx_d_minus   driven bus pair; J = (1,0), K = (0,1), SE0 = (0,0)
//   is_txing                high while the block owns the bus (SYNC .. EOP J)
//   busy                    high whenever a transaction is in progress
//   resp_seen               one-cycle pulse: K seen during the response window
//   timeout                 one-cycle pulse: response window expired
module usb_host_token_tx #(
    parameter int CLKS_PER_BIT = 8,
    parameter int TIMEOUT_BITS = 16
) (
    input  logic       clk,
    input  logic       n_rst,
    input  logic       start,
    input  logic [6:0] addr,
    input  logic [3:0] endp,
`ifdef TOKEN_PID_SEL_EN
    input  logic [1:0] pid_sel,
`endif
    input  logic       rx_d_plus,
    input  logic       rx_d_minus,
    output logic       tx_d_plus,
    output logic       tx_d_minus,
    output logic       is_txing,
    output logic       busy,
    output logic       resp_seen,
    output logic       timeout
);

    localparam int CW   = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int TLIM = TIMEOUT_BITS * CLKS_PER_BIT;
    localparam int TW   = $clog2(TLIM + 1);

    typedef enum logic [2:0] {IDLE, SEND, EOP_SE0, EOP_J, WAIT_RESP} state_e;

    state_e          state_q, state_d;
    logic [31:0]     shift_q, shift_d;     // raw bits still to send, LSB next
    logic [5:0]      raw_cnt_q, raw_cnt_d; // raw bits already started
    logic [2:0]      ones_q, ones_d;       // consecutive 1s on the wire
    logic [CW-1:0]   clk_cnt_q, clk_cnt_d; // position inside the bit time
    logic            line_q, line_d;       // NRZI level, 1 = J
    logic            eop_cnt_q, eop_cnt_d; // which SE0 bit time
    logic [TW-1:0]   tmo_cnt_q, tmo_cnt_d;

    logic [7:0]      pid;
    logic [4:0]      crc;
    logic [31:0]     word;
    logic            bit_end;
    logic            rx_k;

    // USB CRC5 over the 11 token bits in transmission order (addr[0] first).
    function automatic logic [4:0] crc5(input logic [10:0] data);
        logic [4:0] c;
        logic       fb;
        // NOTE: inside a function or always_comb, blocking '=' is correct; each
        // step must see the result of the previous one within the same evaluation.
        c = 5'b11111;
        for (int i = 0; i < 11; i++) begin
            fb = data[i] ^ c[4];
            c  = {c[3:0], 1'b0};
            if (fb) c = c ^ 5'b00101;
        end
        return ~c;
    endfunction

`ifdef TOKEN_PID_SEL_EN
    always_comb begin
        pid = 8'h69;
        case (pid_sel)
            2'b01:   pid = 8'hE1;
            2'b10:   pid = 8'h2D;
            default: pid = 8'h69;
        endcase
    end
`else
    assign pid = 8'h69;
`endif

    // The CRC goes on the wire c4 first, so its bits are placed reversed in the
    // LSB-first shift word.
    assign crc     = crc5({endp, addr});
    assign word    = {crc[0], crc[1], crc[2], crc[3], crc[4], endp, addr, pid, 8'h80};
    assign bit_end = (clk_cnt_q == CW'(CLKS_PER_BIT - 1));
    assign rx_k    = ~rx_d_plus & rx_d_minus;

    always_comb begin
        // NOTE: every signal assigned here gets a default first, so no path
        // through the case statement can leave one unassigned and infer a latch.
        state_d   = state_q;
        shift_d   = shift_q;
        raw_cnt_d = raw_cnt_q;
        ones_d    = ones_q;
        line_d    = line_q;
        eop_cnt_d = eop_cnt_q;
        tmo_cnt_d = tmo_cnt_q;
        clk_cnt_d = bit_end ? '0 : clk_cnt_q + CW'(1);
        resp_seen = 1'b0;
        timeout   = 1'b0;

        case (state_q)
            IDLE: begin
                clk_cnt_d = '0;
                if (start) begin
                    // The first SYNC bit is emitted right away so it is on the
                    // pins in the cycle after start is accepted.
                    state_d   = SEND;
                    line_d    = line_q ^ ~word[0];
                    ones_d    = word[0] ? 3'd1 : 3'd0;
                    shift_d   = {1'b0, word[31:1]};
                    raw_cnt_d = 6'd1;
                end
            end

            SEND: begin
                if (bit_end) begin
                    if (ones_q == 3'd6) begin
                        // Stuffed 0: a forced transition, not taken from the word.
                        line_d = ~line_q;
                        ones_d = 3'd0;
                    end else if (raw_cnt_q != 6'd32) begin
                        line_d    = line_q ^ ~shift_q[0];
                        ones_d    = shift_q[0] ? ones_q + 3'd1 : 3'd0;
                        shift_d   = {1'b0, shift_q[31:1]};
                        raw_cnt_d = raw_cnt_q + 6'd1;
                    end else begin
                        state_d   = EOP_SE0;
                        eop_cnt_d = 1'b0;
                    end
                end
            end

            EOP_SE0: begin
                if (bit_end) begin
                    if (eop_cnt_q) begin
                        state_d = EOP_J;
                        line_d  = 1'b1;
                    end else begin
                        eop_cnt_d = 1'b1;
                    end
                end
            end

            EOP_J: begin
                if (bit_end) begin
                    state_d   = WAIT_RESP;
                    tmo_cnt_d = '0;
                end
            end

            WAIT_RESP: begin
                clk_cnt_d = '0;
                // A response K on the last window cycle still counts as a response.
                if (rx_k) begin
                    resp_seen = 1'b1;
                    state_d   = IDLE;
                end else if (tmo_cnt_q == TW'(TLIM)) begin
                    timeout = 1'b1;
                    state_d = IDLE;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + TW'(1);
                end
            end

            default: state_d = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking '<=' so every flop samples the
    // pre-edge values of the others, independent of process ordering.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q   <= IDLE;
            shift_q   <= '0;
            raw_cnt_q <= '0;
            ones_q    <= '0;
            clk_cnt_q <= '0;
            line_q    <= 1'b1;
            eop_cnt_q <= 1'b0;
            tmo_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            raw_cnt_q <= raw_cnt_d;
            ones_q    <= ones_d;
            clk_cnt_q <= clk_cnt_d;
            line_q    <= line_d;
            eop_cnt_q <= eop_cnt_d;
            tmo_cnt_q <= tmo_cnt_d;
        end
    end

    // Pins decode straight from registered state, so reset forces J at once.
    always_comb begin
        tx_d_plus  = 1'b1;
        tx_d_minus = 1'b0;
        case (state_q)
            SEND: begin
                tx_d_plus  = line_q;
                tx_d_minus = ~line_q;
            end
            EOP_SE0: begin
                tx_d_plus  = 1'b0;
                tx_d_minus = 1'b0;
            end
            default: ;
        endcase
    end

    assign is_txing = (state_q == SEND) || (state_q == EOP_SE0) || (state_q == EOP_J);
    assign busy     = (state_q != IDLE);

endmodule

// File: tb/tb_usb_host_token_tx.sv
module tb_usb_host_token_tx;

    localparam int CPB   = 8;
    localparam int TOB   = 16;
    localparam int LIMIT = TOB * CPB;

    localparam logic [1:0] SYM_J   = 2'b10;
    localparam logic [1:0] SYM_K   = 2'b01;
    localparam logic [1:0] SYM_SE0 = 2'b00;

    logic       clk;
    logic       n_rst;
    logic       start;
    logic [6:0] addr;
    logic [3:0] endp;
    logic [1:0] pid_sel;
    logic       rx_d_plus;
    logic       rx_d_minus;
    logic       tx_d_plus;
    logic       tx_d_minus;
    logic       is_txing;
    logic       busy;
    logic       resp_seen;
    logic       timeout;

    int vectors    = 0;
    int miscompares = 0;

    // Reference model output and captured waveform
    logic [1:0] exp_q[$];   // expected line symbol per bit time
    logic       exp_raw[$]; // expected unstuffed raw bits
    int         exp_stuff;
    logic [1:0] cap_q[$];   // tx pair per cycle while is_txing
    logic       dec_raw[$]; // raw bits recovered by the device-side decoder
    int         dec_stuff;
    int         dec_se0;
    int         dec_jtail;
    int         tx_cycles;

    usb_host_token_tx #(
        .CLKS_PER_BIT(CPB),
        .TIMEOUT_BITS(TOB)
    ) dut (
        .clk        (clk),
        .n_rst      (n_rst),
        .start      (start),
        .addr       (addr),
        .endp       (endp),
`ifdef TOKEN_PID_SEL_EN
        .pid_sel    (pid_sel),
`endif
        .rx_d_plus  (rx_d_plus),
        .rx_d_minus (rx_d_minus),
        .tx_d_plus  (tx_d_plus),
        .tx_d_minus (tx_d_minus),
        .is_txing   (is_txing),
        .busy       (busy),
        .resp_seen  (resp_seen),
        .timeout    (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    function automatic logic [7:0] model_pid(input logic [1:0] ps);
`ifdef TOKEN_PID_SEL_EN
        case (ps)
            2'b01:   return 8'hE1;
            2'b10:   return 8'h2D;
            default: return 8'h69;
        endcase
`else
        return (ps == ps) ? 8'h69 : 8'h69;
`endif
    endfunction

    // CRC5 by polynomial long division. The message is written with the first
    // transmitted bit as the highest power; an all-ones preset equals inverting
    // the first five message bits. Returns c4..c0, c4 sent first.
    function automatic logic [4:0] model_crc(input logic [6:0] a, input logic [3:0] e);
        logic [10:0] msg;
        logic [15:0] v;
        for (int i = 0; i < 7; i++) msg[10-i] = a[i];
        for (int i = 0; i < 4; i++) msg[3-i]  = e[i];
        msg = msg ^ 11'b111_1100_0000;
        v = {msg, 5'b00000};
        for (int d = 15; d >= 5; d--)
            if (v[d]) v = v ^ (16'(6'b100101) << (d - 5));
        return ~v[4:0];
    endfunction

    task automatic build_model(input logic [6:0] a, input logic [3:0] e, input logic [1:0] ps);
        logic [7:0] sync;
        logic [7:0] pid;
        logic [4:0] crc;
        logic [1:0] lvl;
        int         run;
        exp_raw.delete();
        exp_q.delete();
        exp_stuff = 0;
        sync = 8'h80;
        pid  = model_pid(ps);
        crc  = model_crc(a, e);
        for (int i = 0; i < 8; i++) exp_raw.push_back(sync[i]);
        for (int i = 0; i < 8; i++) exp_raw.push_back(pid[i]);
        for (int i = 0; i < 7; i++) exp_raw.push_back(a[i]);
        for (int i = 0; i < 4; i++) exp_raw.push_back(e[i]);
        for (int i = 4; i >= 0; i--) exp_raw.push_back(crc[i]);
        lvl = SYM_J;
        run = 0;
        foreach (exp_raw[i]) begin
            if (!exp_raw[i]) lvl = (lvl == SYM_J) ? SYM_K : SYM_J;
            exp_q.push_back(lvl);
            run = exp_raw[i] ? run + 1 : 0;
            if (run == 6) begin
                lvl = (lvl == SYM_J) ? SYM_K : SYM_J;
                exp_q.push_back(lvl);
                run = 0;
                exp_stuff++;
            end
        end
        exp_q.push_back(SYM_SE0);
        exp_q.push_back(SYM_SE0);
        exp_q.push_back(SYM_J);
    endtask

    // ---------------- capture and device-side decode ----------------
    // Starts a token (DUT must be idle) and records the tx pair until is_txing
    // falls; returns at the falling edge of the first cycle of the response window.
    task automatic capture_packet(input logic [6:0] a, input logic [3:0] e, input logic [1:0] ps);
        int n;
        cap_q.delete();
        @(negedge clk);
        addr = a; endp = e; pid_sel = ps; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        @(negedge clk);
        vectors++;
        if (!(is_txing === 1'b1 && busy === 1'b1)) begin
            miscompares++;
            $display("FAIL first_cycle: is_txing/busy got %b%b expected 11", is_txing, busy);
        end
        n = 0;
        while (is_txing === 1'b1 && n < 4000) begin
            cap_q.push_back({tx_d_plus, tx_d_minus});
            n++;
            @(negedge clk);
        end
        tx_cycles = n;
        vectors++;
        if ({tx_d_plus, tx_d_minus, busy} !== 3'b101) begin
            miscompares++;
            $display("FAIL post_eop: tx pair/busy got %b expected 101", {tx_d_plus, tx_d_minus, busy});
        end
    endtask

    task automatic decode_capture();
        logic [1:0] prev;
        logic [1:0] s;
        logic       b;
        int         ones;
        dec_raw.delete();
        dec_stuff = 0;
        dec_se0   = 0;
        dec_jtail = 0;
        prev = SYM_J;
        ones = 0;
        for (int bt = 0; bt * CPB + CPB / 2 < cap_q.size(); bt++) begin
            s = cap_q[bt * CPB + CPB / 2];
            if (s == SYM_SE0) break;
            b = (s == prev);
            prev = s;
            if (ones == 6) begin
                dec_stuff++;
                ones = 0;
            end else begin
                dec_raw.push_back(b);
                ones = b ? ones + 1 : 0;
            end
        end
        foreach (cap_q[i]) if (cap_q[i] == SYM_SE0) dec_se0++;
        for (int i = cap_q.size() - 1; i >= 0 && cap_q[i] == SYM_J; i--) dec_jtail++;
    endtask

    function automatic logic [15:0] dec_field(input int lo, input int w);
        logic [15:0] v;
        v = '0;
        for (int i = 0; i < w; i++)
            v[i] = (lo + i < dec_raw.size()) ? dec_raw[lo + i] : 1'bx;
        return v;
    endfunction

    task automatic check_packet(input string tag);
        int bad;
        vectors++;
        if (tx_cycles != exp_q.size() * CPB) begin
            miscompares++;
            $display("FAIL %s length: got %0d cycles expected %0d", tag, tx_cycles, exp_q.size() * CPB);
        end
        bad = -1;
        for (int i = 0; i < cap_q.size() && i / CPB < exp_q.size(); i++)
            if (bad < 0 && cap_q[i] !== exp_q[i / CPB]) bad = i;
        vectors++;
        if (bad >= 0) begin
            miscompares++;
            $display("FAIL %s wave: cycle %0d got %b expected %b", tag, bad, cap_q[bad], exp_q[bad / CPB]);
        end
        bad = (dec_raw.size() != exp_raw.size()) ? 0 : -1;
        foreach (exp_raw[i]) if (bad < 0 && dec_raw[i] !== exp_raw[i]) bad = i + 1;
        vectors++;
        if (bad >= 0) begin
            miscompares++;
            $display("FAIL %s raw_bits: got %0d bits expected %0d, first diff at %0d",
                     tag, dec_raw.size(), exp_raw.size(), bad - 1);
        end
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while (busy !== 1'b0 && n < LIMIT + 50) begin
            @(negedge clk);
            n++;
        end
        vectors++;
        if (busy !== 1'b0) begin
            miscompares++;
            $display("FAIL %s idle: busy got %b expected 0 within %0d cycles", tag, busy, LIMIT + 50);
        end
    endtask

    task automatic packet(input string tag, input logic [6:0] a, input logic [3:0] e, input logic [1:0] ps);
        build_model(a, e, ps);
        capture_packet(a, e, ps);
        decode_capture();
        check_packet(tag);
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        #2;
        vectors++;
        if ({tx_d_plus, tx_d_minus, is_txing, busy, resp_seen, timeout} !== 6'b100000) begin
            miscompares++;
            $display("FAIL reset_state: got %b expected 100000",
                     {tx_d_plus, tx_d_minus, is_txing, busy, resp_seen, timeout});
        end
        repeat (2) @(negedge clk);
        n_rst = 1'b1;
        @(negedge clk);
        vectors++;
        if ({tx_d_plus, tx_d_minus, is_txing, busy} !== 4'b1000) begin
            miscompares++;
            $display("FAIL after_reset: got %b expected 1000", {tx_d_plus, tx_d_minus, is_txing, busy});
        end
    endtask

    task automatic test_reset_mid_sync();
        @(negedge clk);
        addr = 7'h2A; endp = 4'h3; pid_sel = 2'b00; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (3 * CPB + 2) @(negedge clk);
        vectors++;
        if (is_txing !== 1'b1) begin
            miscompares++;
            $display("FAIL mid_sync_txing: got %b expected 1", is_txing);
        end
        #2 n_rst = 1'b0;
        #1;
        vectors++;
        if ({tx_d_plus, tx_d_minus, is_txing, busy} !== 4'b1000) begin
            miscompares++;
            $display("FAIL mid_sync_reset: got %b expected 1000", {tx_d_plus, tx_d_minus, is_txing, busy});
        end
        @(negedge clk);
        n_rst = 1'b1;
        packet("post_reset", 7'($urandom), 4'($urandom), 2'($urandom));
        wait_idle("post_reset");
    endtask

    task automatic test_zero_token();
        logic [4:0] crc_lsb;
        packet("zero", 7'h00, 4'h0, 2'b00);
        crc_lsb = 5'(dec_field(27, 5));
        vectors++;
        if (tx_cycles != 35 * CPB || dec_stuff != 0) begin
            miscompares++;
            $display("FAIL zero_len: got %0d cycles, %0d stuffs expected %0d cycles, 0 stuffs",
                     tx_cycles, dec_stuff, 35 * CPB);
        end
        vectors++;
        if (crc_lsb !== 5'b00010) begin
            miscompares++;
            $display("FAIL zero_crc: got %b expected 00010", crc_lsb);
        end
        wait_idle("zero");
    endtask

    task automatic test_crc_15e();
        logic [4:0] crc_msb;
        packet("crc_15e", 7'h15, 4'hE, 2'b00);
        // c4 is sent first, so reading the field MSB-first gives the register value.
        for (int i = 0; i < 5; i++)
            crc_msb[4-i] = (27 + i < dec_raw.size()) ? dec_raw[27 + i] : 1'bx;
        vectors++;
        if (crc_msb !== 5'h17) begin
            miscompares++;
            $display("FAIL crc_15e: got %h expected 17", crc_msb);
        end
        vectors++;
        if (dec_se0 != 2 * CPB || dec_jtail != CPB) begin
            miscompares++;
            $display("FAIL eop_shape: got se0=%0d j=%0d expected se0=%0d j=%0d",
                     dec_se0, dec_jtail, 2 * CPB, CPB);
        end
        wait_idle("crc_15e");
    endtask

    task automatic test_stuffing();
        logic [15:0] a_got;
        logic [15:0] e_got;
        packet("stuff", 7'h7F, 4'hF, 2'b00);
        a_got = dec_field(16, 7);
        e_got = dec_field(23, 4);
        vectors++;
        if (a_got[6:0] !== 7'h7F || e_got[3:0] !== 4'hF) begin
            miscompares++;
            $display("FAIL stuff_fields: got addr=%h endp=%h expected 7f f", a_got[6:0], e_got[3:0]);
        end
        vectors++;
        if (dec_stuff != exp_stuff || dec_stuff == 0 || tx_cycles <= 35 * CPB) begin
            miscompares++;
            $display("FAIL stuff_count: got %0d stuffs %0d cycles expected %0d stuffs >%0d cycles",
                     dec_stuff, tx_cycles, exp_stuff, 35 * CPB);
        end
        wait_idle("stuff");
    endtask

    task automatic test_response();
        int early;
        packet("resp", 7'h41, 4'h2, 2'b00);
        early = 0;
        for (int k = 0; k < 5 * CPB; k++) begin
            if (resp_seen !== 1'b0 || timeout !== 1'b0) early++;
            @(negedge clk);
        end
        rx_d_plus = 1'b0; rx_d_minus = 1'b1;
        #1;
        vectors++;
        if (early != 0 || {resp_seen, timeout, busy} !== 3'b101) begin
            miscompares++;
            $display("FAIL resp_pulse: got early=%0d resp/tmo/busy=%b expected 0 101",
                     early, {resp_seen, timeout, busy});
        end
        @(negedge clk);
        vectors++;
        if ({resp_seen, busy} !== 2'b00) begin
            miscompares++;
            $display("FAIL resp_after: resp/busy got %b expected 00", {resp_seen, busy});
        end
        rx_d_plus = 1'b1; rx_d_minus = 1'b0;
    endtask

    task automatic test_timeout();
        int first;
        int txs;
        int c;
        packet("tmo", 7'h0C, 4'h9, 2'b00);
        first = -1;
        txs = 0;
        c = 0;
        while (c <= LIMIT + 8) begin
            if (c == 3 * CPB) start = 1'b1;
            if (c == 3 * CPB + 1) start = 1'b0;
            if (is_txing !== 1'b0 || resp_seen !== 1'b0) txs++;
            if (timeout === 1'b1) begin
                first = c;
                break;
            end
            @(negedge clk);
            c++;
        end
        start = 1'b0;
        vectors++;
        if (first != LIMIT || txs != 0) begin
            miscompares++;
            $display("FAIL timeout_time: got cycle %0d (bad=%0d) expected cycle %0d (bad=0)", first, txs, LIMIT);
        end
        @(negedge clk);
        vectors++;
        if ({timeout, busy, is_txing} !== 3'b000) begin
            miscompares++;
            $display("FAIL timeout_after: tmo/busy/txing got %b expected 000", {timeout, busy, is_txing});
        end
    endtask

    task automatic test_back_to_back();
        int n;
        @(negedge clk);
        addr = 7'h33; endp = 4'h5; pid_sel = 2'b00; start = 1'b1;
        n = 0;
        @(negedge clk);
        while (timeout !== 1'b1 && n < 600) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        vectors++;
        if (busy !== 1'b0) begin
            miscompares++;
            $display("FAIL b2b_idle: busy got %b expected 0", busy);
        end
        @(negedge clk);
        vectors++;
        if ({is_txing, busy} !== 2'b11) begin
            miscompares++;
            $display("FAIL b2b_restart: txing/busy got %b expected 11", {is_txing, busy});
        end
        start = 1'b0;
        n = 0;
        while (is_txing === 1'b1 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        wait_idle("b2b");
    endtask

    task automatic test_random();
        int d;
        int c;
        int got_kind;
        int got_c;
        int exp_kind;
        int exp_c;
        for (int it = 0; it < 8; it++) begin
            packet("rand", 7'($urandom), 4'($urandom), 2'($urandom));
            d = (it == 3) ? LIMIT : $urandom_range(0, LIMIT + 20);
            exp_kind = (d <= LIMIT) ? 1 : 2;
            exp_c    = (d <= LIMIT) ? d : LIMIT;
            got_kind = 0;
            got_c    = -1;
            c = 0;
            while (c <= LIMIT + 25) begin
                if (c == d) begin
                    rx_d_plus = 1'b0; rx_d_minus = 1'b1;
                end else if (c < d) begin
                    // J or SE0 on rx must not end the window
                    rx_d_plus = 1'($urandom); rx_d_minus = 1'b0;
                end
                #1;
                if (resp_seen === 1'b1 || timeout === 1'b1) begin
                    got_kind = (resp_seen === 1'b1) ? ((timeout === 1'b1) ? 3 : 1) : 2;
                    got_c = c;
                    break;
                end
                @(negedge clk);
                c++;
            end
            vectors++;
            if (got_kind != exp_kind || got_c != exp_c) begin
                miscompares++;
                $display("FAIL rand_resp[%0d]: got kind %0d at %0d expected kind %0d at %0d",
                         it, got_kind, got_c, exp_kind, exp_c);
            end
            @(negedge clk);
            rx_d_plus = 1'b1; rx_d_minus = 1'b0;
            vectors++;
            if (busy !== 1'b0) begin
                miscompares++;
                $display("FAIL rand_idle[%0d]: busy got %b expected 0", it, busy);
            end
        end
    endtask

    initial begin
        n_rst = 1'b0;
        start = 1'b0;
        addr = '0;
        endp = '0;
        pid_sel = '0;
        rx_d_plus = 1'b1;
        rx_d_minus = 1'b0;
        test_reset();
        test_reset_mid_sync();
        test_zero_token();
        test_crc_15e();
        test_stuffing();
        test_response();
        test_timeout();
        test_back_to_back();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
